// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
// Measures the period and high time of a divided clock in reference_clk
// cycles and checks each period against the programmed division ratio.
// It reports every measured period, a lock level, a mismatch pulse and a
// saturating error count.

module clock_ratio_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 reference_clk,
  input  logic                 reset,
  input  logic                 monitor_enable,
  input  logic [5:0]           expected_ratio,
  input  logic                 divided_clk,
  output logic [5:0]           measured_period,
  output logic [5:0]           measured_high,
  output logic                 measure_valid,
  output logic                 ratio_error,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] error_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);
  localparam logic [6:0] PCNT_TIMEOUT = 7'd64;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic [5:0]             ratio_q, ratio_d;
  logic [6:0]             pcnt_q, pcnt_d;
  logic [6:0]             hcnt_q, hcnt_d;
  logic [3:0]             lock_cnt_q, lock_cnt_d;
  logic [5:0]             measured_period_q, measured_period_d;
  logic [5:0]             measured_high_q, measured_high_d;
  logic                   measure_valid_q, measure_valid_d;
  logic                   ratio_error_q, ratio_error_d;
  logic                   locked_q, locked_d;
  logic [ERR_CNT_W-1:0]   error_count_q, error_count_d;

  logic       s;
  logic       rise;
  logic       ratio_change;
  logic       check_on;
  logic       report;
  logic       report_timeout;
  logic       is_match;
  logic [6:0] half_ratio;
  logic [3:0] lock_cnt_inc;

  assign s            = sync_q[SYNC_STAGES-1];
  assign rise         = s & ~s_dly_q;
  assign ratio_change = (expected_ratio != ratio_q);
  assign check_on     = (ratio_q >= 6'd2);
  assign half_ratio   = {2'b00, ratio_q[5:1]};
  assign lock_cnt_inc = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;

  // Odd ratios accept either duty phase, so the high time may be N>>1 or one more.
  always_comb begin
    is_match = (pcnt_q == {1'b0, ratio_q}) &&
               ((hcnt_q == half_ratio) ||
                (ratio_q[0] && (hcnt_q == half_ratio + 7'd1)));
  end

  // Next-state logic: enable and ratio change take priority over edges and timeouts.
  always_comb begin
    state_d           = state_q;
    sync_d            = {sync_q[SYNC_STAGES-2:0], divided_clk};
    s_dly_d           = s;
    ratio_d           = expected_ratio;
    pcnt_d            = pcnt_q;
    hcnt_d            = hcnt_q;
    lock_cnt_d        = lock_cnt_q;
    measured_period_d = measured_period_q;
    measured_high_d   = measured_high_q;
    measure_valid_d   = 1'b0;
    ratio_error_d     = 1'b0;
    locked_d          = locked_q;
    error_count_d     = error_count_q;
    report            = 1'b0;
    report_timeout    = 1'b0;

    if (!monitor_enable) begin
      state_d    = IDLE;
      locked_d   = 1'b0;
      lock_cnt_d = 4'd0;
    end else if (ratio_change) begin
      state_d    = WAIT_EDGE;
      locked_d   = 1'b0;
      lock_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (rise) begin
            state_d = MEASURE;
            pcnt_d  = 7'd1;
            hcnt_d  = 7'd1;
          end
        end
        MEASURE: begin
          if (rise) begin
            report = 1'b1;
            pcnt_d = 7'd1;
            hcnt_d = 7'd1;
          end else if (pcnt_q == PCNT_TIMEOUT) begin
            report         = 1'b1;
            report_timeout = 1'b1;
            state_d        = WAIT_EDGE;
          end else begin
            pcnt_d = pcnt_q + 7'd1;
            hcnt_d = hcnt_q + {6'd0, s};
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (report) begin
      measure_valid_d   = 1'b1;
      measured_period_d = report_timeout ? 6'd0 : pcnt_q[5:0];
      measured_high_d   = report_timeout ? 6'd0 : hcnt_q[5:0];
      if (!check_on) begin
        lock_cnt_d = 4'd0;
        locked_d   = 1'b0;
      end else if (!report_timeout && is_match) begin
        lock_cnt_d = lock_cnt_inc;
        locked_d   = (lock_cnt_inc == LOCK_MAX);
      end else begin
        ratio_error_d = 1'b1;
        lock_cnt_d    = 4'd0;
        locked_d      = 1'b0;
        if (!(&error_count_q)) begin
          error_count_d = error_count_q + 1'b1;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      sync_q            <= '0;
      s_dly_q           <= 1'b0;
      ratio_q           <= 6'd0;
      pcnt_q            <= 7'd0;
      hcnt_q            <= 7'd0;
      lock_cnt_q        <= 4'd0;
      measured_period_q <= 6'd0;
      measured_high_q   <= 6'd0;
      measure_valid_q   <= 1'b0;
      ratio_error_q     <= 1'b0;
      locked_q          <= 1'b0;
      error_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      sync_q            <= sync_d;
      s_dly_q           <= s_dly_d;
      ratio_q           <= ratio_d;
      pcnt_q            <= pcnt_d;
      hcnt_q            <= hcnt_d;
      lock_cnt_q        <= lock_cnt_d;
      measured_period_q <= measured_period_d;
      measured_high_q   <= measured_high_d;
      measure_valid_q   <= measure_valid_d;
      ratio_error_q     <= ratio_error_d;
      locked_q          <= locked_d;
      error_count_q     <= error_count_d;
    end
  end

  assign measured_period = measured_period_q;
  assign measured_high   = measured_high_q;
  assign measure_valid   = measure_valid_q;
  assign ratio_error     = ratio_error_q;
  assign locked          = locked_q;
  assign error_count     = error_count_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb_clock_ratio_monitor
// Directed bench for clock_ratio_monitor: drives divided_clk waveforms,
// records every measure_valid pulse and compares against hand-computed values.

module tb_clock_ratio_monitor;

  logic       reference_clk = 1'b0;
  logic       reset = 1'b0;
  logic       monitor_enable = 1'b0;
  logic [5:0] expected_ratio = 6'd0;
  logic       divided_clk = 1'b0;
  logic [5:0] measured_period;
  logic [5:0] measured_high;
  logic       measure_valid;
  logic       ratio_error;
  logic       locked;
  logic [7:0] error_count;

  typedef struct packed {
    logic [5:0] per;
    logic [5:0] hi;
    logic       err;
    logic       lk;
    logic [7:0] ec;
    int         cyc;
  } meas_t;

  meas_t mq[$];
  int    cycle_cnt = 0;
  int    check_count = 0;
  int    fail_count = 0;

  clock_ratio_monitor #(
    .SYNC_STAGES(2),
    .LOCK_COUNT (4),
    .ERR_CNT_W  (8)
  ) dut (
    .reference_clk  (reference_clk),
    .reset          (reset),
    .monitor_enable (monitor_enable),
    .expected_ratio (expected_ratio),
    .divided_clk    (divided_clk),
    .measured_period(measured_period),
    .measured_high  (measured_high),
    .measure_valid  (measure_valid),
    .ratio_error    (ratio_error),
    .locked         (locked),
    .error_count    (error_count)
  );

  // Reference clock, 10 time units per cycle.
  always #5 reference_clk = ~reference_clk;

  // Free-running cycle index used to time measurements.
  always @(posedge reference_clk) cycle_cnt <= cycle_cnt + 1;

  // Record every reported measurement, sampled on the falling edge.
  always @(negedge reference_clk) begin
    if (measure_valid === 1'b1) begin
      mq.push_back('{per: measured_period, hi: measured_high, err: ratio_error,
                     lk: locked, ec: error_count, cyc: cycle_cnt});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge reference_clk);
    #1;
  endtask

  task automatic applyStimulus(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      divided_clk = 1'b1;
      repeat (hi) waitCycle();
      divided_clk = 1'b0;
      repeat (lo) waitCycle();
    end
  endtask

  function automatic meas_t getMeas(input int idx);
    meas_t m;
    m = '0;
    if (idx < mq.size()) m = mq[idx];
    return m;
  endfunction

  // Safety net so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    meas_t m;
    int    bad;
    int    exp_ec;

    // Reset state
    expected_ratio = 6'd4;
    repeat (3) waitCycle();
    checkOutput("rst_period", measured_period, 0);
    checkOutput("rst_high", measured_high, 0);
    checkOutput("rst_valid", measure_valid, 0);
    checkOutput("rst_err", ratio_error, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_errcnt", error_count, 0);
    reset = 1'b1;
    repeat (3) waitCycle();

    // Test 1: ratio 4, 2 high / 2 low
    $display("[TB] test 1: ratio 4 lock");
    monitor_enable = 1'b1;
    repeat (5) waitCycle();
    mq.delete();
    applyStimulus(2, 2, 6);
    checkOutput("t1_count", mq.size(), 5);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      m = getMeas(k);
      if (m.per !== 6'd4 || m.hi !== 6'd2 || m.err !== 1'b0 || m.lk !== (k >= 3)) bad++;
    end
    checkOutput("t1_meas_bad", bad, 0);
    checkOutput("t1_lock3", getMeas(2).lk, 0);
    checkOutput("t1_lock4", getMeas(3).lk, 1);
    checkOutput("t1_spacing", getMeas(1).cyc - getMeas(0).cyc, 4);
    checkOutput("t1_errcnt", error_count, 0);

    // Test 4: hold divided_clk low until timeout, then relock
    $display("[TB] test 4: timeout and relock");
    for (int w = 0; w < 100; w++) begin
      if (mq.size() >= 6) break;
      waitCycle();
    end
    checkOutput("t4_timeout_seen", mq.size(), 6);
    m = getMeas(5);
    checkOutput("t4_period", m.per, 0);
    checkOutput("t4_high", m.hi, 0);
    checkOutput("t4_err", m.err, 1);
    checkOutput("t4_locked", m.lk, 0);
    checkOutput("t4_errcnt", m.ec, 1);
    checkOutput("t4_delay", m.cyc - getMeas(4).cyc, 64);
    mq.delete();
    applyStimulus(2, 2, 6);
    checkOutput("t4_relock_count", mq.size(), 5);
    checkOutput("t4_relock_first", getMeas(0).lk, 0);
    checkOutput("t4_relock_third", getMeas(2).lk, 0);
    checkOutput("t4_relock_fourth", getMeas(3).lk, 1);

    // Test 5: ratio change while locked
    $display("[TB] test 5: ratio change 4 -> 6");
    checkOutput("t5_locked_before", locked, 1);
    expected_ratio = 6'd6;
    waitCycle();
    checkOutput("t5_locked_drop", locked, 0);
    mq.delete();
    applyStimulus(3, 3, 6);
    checkOutput("t5_count", mq.size(), 5);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      m = getMeas(k);
      if (m.per !== 6'd6 || m.hi !== 6'd3 || m.err !== 1'b0 || m.lk !== (k >= 3)) bad++;
    end
    checkOutput("t5_meas_bad", bad, 0);
    checkOutput("t5_errcnt", error_count, 1);
    monitor_enable = 1'b0;
    repeat (3) waitCycle();
    mq.delete();

    // Test 2: ratio 5, high time alternating 2 / 3
    $display("[TB] test 2: ratio 5 alternating duty");
    expected_ratio = 6'd5;
    monitor_enable = 1'b1;
    repeat (4) waitCycle();
    mq.delete();
    for (int p = 0; p < 6; p++) begin
      if (p % 2 == 0) applyStimulus(2, 3, 1);
      else            applyStimulus(3, 2, 1);
    end
    checkOutput("t2_count", mq.size(), 5);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      m = getMeas(k);
      if (m.per !== 6'd5 || m.hi !== ((k % 2 == 0) ? 6'd2 : 6'd3) || m.err !== 1'b0) bad++;
    end
    checkOutput("t2_meas_bad", bad, 0);
    checkOutput("t2_high1", getMeas(1).hi, 3);
    checkOutput("t2_lock3", getMeas(2).lk, 0);
    checkOutput("t2_lock4", getMeas(3).lk, 1);
    monitor_enable = 1'b0;
    repeat (3) waitCycle();
    mq.delete();

    // Test 3: ratio 6 but period 8, error counter saturation
    $display("[TB] test 3: persistent mismatch");
    expected_ratio = 6'd6;
    monitor_enable = 1'b1;
    repeat (4) waitCycle();
    mq.delete();
    applyStimulus(4, 4, 300);
    checkOutput("t3_count", mq.size(), 299);
    bad = 0;
    for (int k = 0; k < 299; k++) begin
      m = getMeas(k);
      exp_ec = (k + 2 > 255) ? 255 : k + 2;
      if (m.per !== 6'd8 || m.hi !== 6'd4 || m.err !== 1'b1 || m.lk !== 1'b0 || m.ec !== 8'(exp_ec)) bad++;
    end
    checkOutput("t3_meas_bad", bad, 0);
    checkOutput("t3_ec_first", getMeas(0).ec, 2);
    checkOutput("t3_ec_second", getMeas(1).ec, 3);
    checkOutput("t3_ec_254", getMeas(252).ec, 254);
    checkOutput("t3_ec_sat", getMeas(253).ec, 255);
    checkOutput("t3_ec_last", getMeas(298).ec, 255);
    monitor_enable = 1'b0;
    repeat (3) waitCycle();
    mq.delete();

    // Test 6a: enable low mid-period
    $display("[TB] test 6: enable low and reset mid-period");
    expected_ratio = 6'd4;
    monitor_enable = 1'b1;
    repeat (4) waitCycle();
    mq.delete();
    applyStimulus(2, 2, 6);
    checkOutput("t6_count", mq.size(), 5);
    checkOutput("t6_locked_before", locked, 1);
    divided_clk = 1'b1;
    waitCycle();
    monitor_enable = 1'b0;
    repeat (2) waitCycle();
    checkOutput("t6_locked_off", locked, 0);
    applyStimulus(2, 2, 3);
    checkOutput("t6_no_valid", mq.size(), 5);
    checkOutput("t6_hold_period", measured_period, 4);
    checkOutput("t6_hold_high", measured_high, 2);
    checkOutput("t6_hold_errcnt", error_count, 255);

    // Test 6b: reset low mid-period
    monitor_enable = 1'b1;
    applyStimulus(2, 2, 3);
    divided_clk = 1'b1;
    waitCycle();
    reset = 1'b0;
    #2;
    checkOutput("t6_rst_period", measured_period, 0);
    checkOutput("t6_rst_high", measured_high, 0);
    checkOutput("t6_rst_valid", measure_valid, 0);
    checkOutput("t6_rst_err", ratio_error, 0);
    checkOutput("t6_rst_locked", locked, 0);
    checkOutput("t6_rst_errcnt", error_count, 0);
    waitCycle();
    reset = 1'b1;
    divided_clk = 1'b0;
    repeat (2) waitCycle();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
